// File: rtl/scale_coord_gen.sv
// rtl/scale_coord_gen.sv - raster walker emitting destination/source coordinate beats for the scaler
// Optional build macro SCALE_COORD_CLAMP_EN saturates src_x/src_y to the source image bounds.
module scale_coord_gen #(
    parameter int SRC_H_NUM = 1280,
    parameter int SRC_V_NUM = 720,
    parameter int MAX_H_NUM = 1920,
    parameter int MAX_V_NUM = 1080,
    parameter int FRAC_BITS = 12
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_start,
    input  logic [14:0] x_scale,
    input  logic [14:0] y_scale,
    input  logic [10:0] target_h_num,
    input  logic [10:0] target_v_num,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [10:0] dst_x,
    output logic [10:0] dst_y,
    output logic [10:0] src_x,
    output logic [10:0] src_y,
    output logic [11:0] src_x_frac,
    output logic [11:0] src_y_frac,
    output logic        line_end,
    output logic        frame_end,
    output logic        busy,
    output logic        frame_done,
    output logic        cfg_err,
    output logic        frame_miss
);

    typedef enum logic [1:0] {IDLE, LATCH, RUN, DONE} state_t;

    state_t      state;
    logic [14:0] x_sh, y_sh;
    logic [10:0] h_sh, v_sh;
    logic [25:0] acc_x, acc_y;

    logic        accept, load, cfg_bad;
    logic [10:0] nx_dx, nx_dy, nx_sx, nx_sy;
    logic [25:0] nx_ax, nx_ay;
    logic [11:0] nx_fx, nx_fy;
    logic        nx_le, nx_fe;

    assign accept  = (state == RUN) && out_valid && out_ready;
    assign cfg_bad = (target_h_num == 11'd0) || (target_h_num > 11'(MAX_H_NUM)) ||
                     (target_v_num == 11'd0) || (target_v_num > 11'(MAX_V_NUM)) ||
                     (x_scale == 15'd0) || (y_scale == 15'd0);

    // Next beat is computed here so every output field is a plain register.
    always_comb begin
        nx_dx = dst_x;
        nx_dy = dst_y;
        nx_ax = acc_x;
        nx_ay = acc_y;
        load  = 1'b0;
        if (state == LATCH && !cfg_err) begin
            load  = 1'b1;
            nx_dx = 11'd0;
            nx_dy = 11'd0;
            nx_ax = 26'd0;
            nx_ay = 26'd0;
        end else if (accept && !frame_end) begin
            load = 1'b1;
            if (line_end) begin
                nx_dx = 11'd0;
                nx_ax = 26'd0;
                nx_dy = dst_y + 11'd1;
                nx_ay = acc_y + {11'd0, y_sh};
            end else begin
                nx_dx = dst_x + 11'd1;
                nx_ax = acc_x + {11'd0, x_sh};
            end
        end
        nx_sx = 11'(nx_ax >> FRAC_BITS);
        nx_sy = 11'(nx_ay >> FRAC_BITS);
        nx_fx = nx_ax[FRAC_BITS-1:0];
        nx_fy = nx_ay[FRAC_BITS-1:0];
`ifdef SCALE_COORD_CLAMP_EN
        if ((nx_ax >> FRAC_BITS) > 26'(SRC_H_NUM - 1)) begin
            nx_sx = 11'(SRC_H_NUM - 1);
            nx_fx = 12'd0;
        end
        if ((nx_ay >> FRAC_BITS) > 26'(SRC_V_NUM - 1)) begin
            nx_sy = 11'(SRC_V_NUM - 1);
            nx_fy = 12'd0;
        end
`endif
        nx_le = (nx_dx == h_sh - 11'd1);
        nx_fe = nx_le && (nx_dy == v_sh - 11'd1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            x_sh       <= '0;
            y_sh       <= '0;
            h_sh       <= '0;
            v_sh       <= '0;
            acc_x      <= '0;
            acc_y      <= '0;
            out_valid  <= 1'b0;
            dst_x      <= '0;
            dst_y      <= '0;
            src_x      <= '0;
            src_y      <= '0;
            src_x_frac <= '0;
            src_y_frac <= '0;
            line_end   <= 1'b0;
            frame_end  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            frame_miss <= 1'b0;
        end else begin
            cfg_err    <= 1'b0;
            frame_done <= 1'b0;
            frame_miss <= frame_start && (state != IDLE);
            if (load) begin
                dst_x      <= nx_dx;
                dst_y      <= nx_dy;
                acc_x      <= nx_ax;
                acc_y      <= nx_ay;
                src_x      <= nx_sx;
                src_y      <= nx_sy;
                src_x_frac <= nx_fx;
                src_y_frac <= nx_fy;
                line_end   <= nx_le;
                frame_end  <= nx_fe;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        x_sh    <= x_scale;
                        y_sh    <= y_scale;
                        h_sh    <= target_h_num;
                        v_sh    <= target_v_num;
                        // Checked on the live inputs, which equal the shadow copy, so the pulse lands in LATCH.
                        cfg_err <= cfg_bad;
                        busy    <= 1'b1;
                        state   <= LATCH;
                    end
                end
                LATCH: begin
                    if (cfg_err) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (accept && frame_end) begin
                        out_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
